// File: rtl/input_conditioner.sv
// Per-bit input conditioner: 2-flop synchroniser, debounce, edge pulses, toggle latch.
// Optional rise-event counter on bit 0 is enabled by defining INPUT_COND_EVENT_CNT_EN.
module input_conditioner #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] toggle_out,
  output logic             stable,
  output logic [7:0]       event_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]            s1_d, s1_q;
  logic [WIDTH-1:0]            s2_d, s2_q;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_d, cnt_q;
  logic [WIDTH-1:0]            level_d, level_q;
  logic [WIDTH-1:0]            rise_d, rise_q;
  logic [WIDTH-1:0]            fall_d, fall_q;
  logic [WIDTH-1:0]            toggle_d, toggle_q;

  // Next-state for synchroniser and per-bit debounce; the synchroniser ignores ena.
  always_comb begin
    s1_d     = raw_in;
    s2_d     = s1_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    toggle_d = toggle_q;
    rise_d   = '0;
    fall_d   = '0;
    if (ena) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s2_q[i] == level_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          level_d[i]  = s2_q[i];
          cnt_d[i]    = '0;
          rise_d[i]   = s2_q[i];
          fall_d[i]   = ~s2_q[i];
          toggle_d[i] = toggle_q[i] ^ s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end else begin
      cnt_d    = cnt_q;
      level_d  = level_q;
      toggle_d = toggle_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      cnt_q    <= '0;
      level_q  <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      toggle_q <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      toggle_q <= toggle_d;
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign toggle_out = toggle_q;
  assign stable     = ~|cnt_q;

`ifdef INPUT_COND_EVENT_CNT_EN
  logic [7:0] event_d, event_q;

  // Counts bit-0 rises on the same edge that raises rise_pulse[0]; wraps naturally.
  always_comb begin
    if (rise_d[0]) begin
      event_d = event_q + 8'd1;
    end else begin
      event_d = event_q;
    end
  end

  // Event counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      event_q <= 8'h00;
    end else begin
      event_q <= event_d;
    end
  end

  assign event_count = event_q;
`else
  assign event_count = 8'h00;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Directed self-checking bench for input_conditioner (WIDTH=4, DEBOUNCE_CYCLES=4).
module tb_input_conditioner;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [3:0] raw_in;
  logic [3:0] level_out;
  logic [3:0] rise_pulse;
  logic [3:0] fall_pulse;
  logic [3:0] toggle_out;
  logic       stable;
  logic [7:0] event_count;

  int total = 0;
  int bad   = 0;

  logic [3:0] rise_acc;
  logic [3:0] fall_acc;
  int         rise_n;
  int         fall_n;
  logic [7:0] exp_event;

  input_conditioner #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .raw_in     (raw_in),
    .level_out  (level_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .toggle_out (toggle_out),
    .stable     (stable),
    .event_count(event_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n cycles, accumulating pulse activity (bit 'b' counted individually).
  task automatic watch(input int n, input int b);
    rise_acc = 4'h0;
    fall_acc = 4'h0;
    rise_n   = 0;
    fall_n   = 0;
    for (int k = 0; k < n; k++) begin
      step(1);
      rise_acc = rise_acc | rise_pulse;
      fall_acc = fall_acc | fall_pulse;
      if (rise_pulse[b]) rise_n++;
      if (fall_pulse[b]) fall_n++;
      if ((rise_pulse & fall_pulse) != 4'h0) chk("rise_fall_overlap", 32'(rise_pulse & fall_pulse), 32'h0);
    end
  endtask

  initial begin
`ifdef INPUT_COND_EVENT_CNT_EN
    exp_event = 8'h01;
`else
    exp_event = 8'h00;
`endif
    // 1. reset then release with all inputs high
    rst_n  = 1'b0;
    ena    = 1'b1;
    raw_in = 4'hF;
    step(2);
    chk("rst_level",  32'(level_out),  32'h0);
    chk("rst_rise",   32'(rise_pulse), 32'h0);
    chk("rst_fall",   32'(fall_pulse), 32'h0);
    chk("rst_toggle", 32'(toggle_out), 32'h0);
    chk("rst_stable", 32'(stable),     32'h1);
    chk("rst_event",  32'(event_count), 32'h0);
    rst_n = 1'b1;
    step(5);
    chk("rel_level_early",  32'(level_out), 32'h0);
    chk("rel_stable_busy",  32'(stable),    32'h0);
    step(1);
    chk("rel_level",  32'(level_out),  32'hF);
    chk("rel_rise",   32'(rise_pulse), 32'hF);
    chk("rel_toggle", 32'(toggle_out), 32'hF);
    chk("rel_stable", 32'(stable),     32'h1);
    step(1);
    chk("rel_rise_one_cycle", 32'(rise_pulse), 32'h0);

    // all inputs low -> simultaneous falls, toggles unaffected
    raw_in = 4'h0;
    step(5);
    chk("fall_level_early", 32'(level_out), 32'hF);
    step(1);
    chk("fall_level",  32'(level_out),  32'h0);
    chk("fall_pulse",  32'(fall_pulse), 32'hF);
    chk("fall_rise",   32'(rise_pulse), 32'h0);
    chk("fall_toggle", 32'(toggle_out), 32'hF);
    step(1);
    chk("fall_one_cycle", 32'(fall_pulse), 32'h0);

    // 2. glitch on bit 1: high for 3 cycles only
    raw_in = 4'h2;
    step(3);
    raw_in = 4'h0;
    step(1);
    chk("glitch_stable_busy", 32'(stable), 32'h0);
    watch(6, 1);
    chk("glitch_level",  32'(level_out),  32'h0);
    chk("glitch_rise",   32'(rise_acc),   32'h0);
    chk("glitch_toggle", 32'(toggle_out), 32'hF);
    chk("glitch_stable", 32'(stable),     32'h1);

    // 3. press/release bit 2 from a clean reset
    rst_n  = 1'b0;
    raw_in = 4'h0;
    step(1);
    rst_n  = 1'b1;
    raw_in = 4'h4;
    watch(10, 2);
    chk("press_rise_count", 32'(rise_n),     32'd1);
    chk("press_level",      32'(level_out),  32'h4);
    chk("press_toggle",     32'(toggle_out), 32'h4);
    raw_in = 4'h0;
    watch(10, 2);
    chk("release_fall_count", 32'(fall_n),     32'd1);
    chk("release_rise_none",  32'(rise_n),     32'd0);
    chk("release_level",      32'(level_out),  32'h0);
    chk("release_toggle",     32'(toggle_out), 32'h4);
    raw_in = 4'h4;
    watch(10, 2);
    chk("press2_rise_count", 32'(rise_n),     32'd1);
    chk("press2_toggle",     32'(toggle_out), 32'h0);
    raw_in = 4'h0;
    watch(10, 2);
    chk("release2_level", 32'(level_out), 32'h0);

    // 4. freeze bit 3 debounce at cnt=2
    raw_in = 4'h8;
    step(4);
    chk("freeze_stable_busy", 32'(stable), 32'h0);
    ena = 1'b0;
    watch(5, 3);
    chk("freeze_level", 32'(level_out), 32'h0);
    chk("freeze_rise",  32'(rise_acc),  32'h0);
    chk("freeze_fall",  32'(fall_acc),  32'h0);
    ena = 1'b1;
    step(1);
    chk("resume_level_early", 32'(level_out), 32'h0);
    step(1);
    chk("resume_level", 32'(level_out),  32'h8);
    chk("resume_rise",  32'(rise_pulse), 32'h8);
    raw_in = 4'h0;
    watch(10, 3);
    chk("resume_release", 32'(level_out), 32'h0);

    // 5. reset with cnt[0]=3
    raw_in = 4'h1;
    step(5);
    chk("mid_level",  32'(level_out), 32'h0);
    chk("mid_stable", 32'(stable),    32'h0);
    rst_n = 1'b0;
    step(1);
    chk("mid_rst_stable", 32'(stable),     32'h1);
    chk("mid_rst_level",  32'(level_out),  32'h0);
    chk("mid_rst_toggle", 32'(toggle_out), 32'h0);
    rst_n = 1'b1;
    step(5);
    chk("mid_relaunch_early", 32'(level_out), 32'h0);
    step(1);
    chk("mid_relaunch_level", 32'(level_out),  32'h1);
    chk("mid_relaunch_rise",  32'(rise_pulse), 32'h1);

    // 6. 257 rises on bit 0 from reset
    rst_n  = 1'b0;
    raw_in = 4'h0;
    step(1);
    chk("evt_rst", 32'(event_count), 32'h0);
    rst_n = 1'b1;
    for (int r = 0; r < 257; r++) begin
      raw_in = 4'h1;
      step(6);
      raw_in = 4'h0;
      step(6);
    end
    chk("evt_count",  32'(event_count), 32'(exp_event));
    chk("evt_toggle", 32'(toggle_out),  32'h1);
    chk("evt_level",  32'(level_out),   32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
